// File: rtl/fm_buf_reader_pkg.sv
// Shared types for the feature-map buffer read path: token kinds, output beat
// record and the helpers that classify tokens and form beat data.
package fm_buf_reader_pkg;

   localparam int FM_BUF_DEPTH = 4096;

   typedef enum logic [1:0] {
      TOK_PAD = 2'd0,
      TOK_RD  = 2'd1,
      TOK_HI  = 2'd2
   } fm_tok_e;

   typedef struct packed {
      logic [7:0] data;
      logic       sol;
      logic       eoc;
      logic       last;
   } fm_beat_t;

   function automatic fm_tok_e tok_sel(input logic interior, input logic bit_mode, input logic odd);
      fm_tok_e t;
      if (!interior) begin
         t = TOK_PAD;
      end else if (bit_mode && odd) begin
         t = TOK_HI;
      end else begin
         t = TOK_RD;
      end
      return t;
   endfunction

   function automatic logic [7:0] beat_data(input fm_tok_e tok, input logic bit_mode,
                                            input logic [7:0] rd_byte, input logic [3:0] held_hi);
      logic [7:0] d;
      case (tok)
         TOK_RD:  d = bit_mode ? {4'h0, rd_byte[3:0]} : rd_byte;
         TOK_HI:  d = {4'h0, held_hi};
         default: d = 8'h00;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/fm_buf_reader_out_fifo.sv
// Small synchronous FIFO of output beats; the reader's credit check keeps it
// from ever being pushed while full.
module fm_out_fifo
   import fm_buf_reader_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  fm_beat_t      push_beat,
   input  logic          pop,
   output fm_beat_t      head,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fm_beat_t        mem_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic            push_ok_s;
   logic            pop_ok_s;

   assign pop_ok_s  = pop && (count_r != CW'(0));
   assign push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_ok_s);
   assign head      = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= CW'(0);
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_beat;
            wr_ptr_r <= (wr_ptr_r == PW'(DEPTH - 1)) ? PW'(0) : wr_ptr_r + PW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= (rd_ptr_r == PW'(DEPTH - 1)) ? PW'(0) : rd_ptr_r + PW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/fm_buf_reader.sv
// Read side of the feature-map buffer: walks a stored FM per job and streams
// one pixel per beat, adding a zero guard ring (3x3) and unpacking nibbles (4-bit).
module fm_buf_reader
   import fm_buf_reader_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid,
   output logic                  ready,
   output logic                  finish,
   input  logic [7:0]            w_num_i,
   input  logic [7:0]            h_num_i,
   input  logic [7:0]            c_num_i,
   input  logic                  kernal_mode_i,
   input  logic                  bit_mode_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   output logic                  fm_buf_rd_en_o,
   output logic [ADDR_WIDTH-1:0] fm_buf_rd_addr_o,
   input  logic [7:0]            fm_buf_data_i,
   output logic                  fm_valid_o,
   input  logic                  fm_ready_i,
   output logic [7:0]            fm_data_o,
   output logic                  fm_sol_o,
   output logic                  fm_eoc_o,
   output logic                  fm_last_o
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   state_e                state_r;
   logic                  ready_r;
   logic                  finish_r;
   logic [7:0]            w_num_r;
   logic [7:0]            h_num_r;
   logic [7:0]            c_num_r;
   logic                  kmode_r;
   logic                  bmode_r;
   logic [8:0]            col_r;
   logic [8:0]            row_r;
   logic [7:0]            ch_r;
   logic [ADDR_WIDTH-1:0] nxt_addr_r;
   logic                  rd_en_r;
   logic [ADDR_WIDTH-1:0] rd_addr_r;
   logic                  a_valid_r, a_sol_r, a_eoc_r, a_last_r;
   fm_tok_e               a_tok_r;
   logic                  b_valid_r, b_sol_r, b_eoc_r, b_last_r;
   fm_tok_e               b_tok_r;
   logic [3:0]            held_hi_r;

   logic [8:0]            col_last_s;
   logic [8:0]            row_last_s;
   logic                  interior_s;
   logic                  odd_s;
   fm_tok_e               tok_s;
   logic                  sol_s, eoc_s, last_s;
   logic [1:0]            inflight_s;
   logic [CW-1:0]         fifo_count_s;
   logic                  issue_s;
   logic                  pop_s;
   fm_beat_t              push_beat_s;
   fm_beat_t              head_s;

   // Position classification in the (optionally padded) scan space.
   assign col_last_s = kmode_r ? ({1'b0, w_num_r} + 9'd2) : {1'b0, w_num_r};
   assign row_last_s = kmode_r ? ({1'b0, h_num_r} + 9'd2) : {1'b0, h_num_r};
   assign interior_s = !kmode_r || ((col_r != 9'd0) && (col_r != col_last_s) &&
                                    (row_r != 9'd0) && (row_r != row_last_s));
   assign odd_s      = kmode_r ? ~col_r[0] : col_r[0];
   assign tok_s      = tok_sel(interior_s, bmode_r, odd_s);
   assign sol_s      = (col_r == 9'd0);
   assign eoc_s      = (col_r == col_last_s) && (row_r == row_last_s);
   assign last_s     = eoc_s && (ch_r == c_num_r);

   // Tokens already issued but not yet in the FIFO hold a credit each.
   assign inflight_s = {1'b0, a_valid_r} + {1'b0, b_valid_r};
   assign issue_s    = (state_r == S_RUN) &&
                       (({1'b0, fifo_count_s} + {{(CW - 1){1'b0}}, inflight_s}) < (CW + 1)'(FIFO_DEPTH));

   assign push_beat_s = '{data: beat_data(b_tok_r, bmode_r, fm_buf_data_i, held_hi_r),
                          sol: b_sol_r, eoc: b_eoc_r, last: b_last_r};

   assign fm_valid_o       = (fifo_count_s != CW'(0));
   assign pop_s            = fm_valid_o && fm_ready_i;
   assign fm_data_o        = head_s.data;
   assign fm_sol_o         = head_s.sol;
   assign fm_eoc_o         = head_s.eoc;
   assign fm_last_o        = head_s.last;
   assign ready            = ready_r;
   assign finish           = finish_r;
   assign fm_buf_rd_en_o   = rd_en_r;
   assign fm_buf_rd_addr_o = rd_addr_r;

   fm_out_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (b_valid_r),
      .push_beat (push_beat_s),
      .pop       (pop_s),
      .head      (head_s),
      .count     (fifo_count_s)
   );

   // Job FSM, scan counters, read strobe and the two-stage token pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         ready_r    <= 1'b1;
         finish_r   <= 1'b0;
         w_num_r    <= 8'd0;
         h_num_r    <= 8'd0;
         c_num_r    <= 8'd0;
         kmode_r    <= 1'b0;
         bmode_r    <= 1'b0;
         col_r      <= 9'd0;
         row_r      <= 9'd0;
         ch_r       <= 8'd0;
         nxt_addr_r <= '0;
         rd_en_r    <= 1'b0;
         rd_addr_r  <= '0;
         a_valid_r  <= 1'b0;
         a_tok_r    <= TOK_PAD;
         a_sol_r    <= 1'b0;
         a_eoc_r    <= 1'b0;
         a_last_r   <= 1'b0;
         b_valid_r  <= 1'b0;
         b_tok_r    <= TOK_PAD;
         b_sol_r    <= 1'b0;
         b_eoc_r    <= 1'b0;
         b_last_r   <= 1'b0;
         held_hi_r  <= 4'h0;
      end else begin
         finish_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (valid && ready_r) begin
                  w_num_r    <= w_num_i;
                  h_num_r    <= h_num_i;
                  c_num_r    <= c_num_i;
                  kmode_r    <= kernal_mode_i;
                  bmode_r    <= bit_mode_i;
                  col_r      <= 9'd0;
                  row_r      <= 9'd0;
                  ch_r       <= 8'd0;
                  nxt_addr_r <= base_addr_i;
                  ready_r    <= 1'b0;
                  state_r    <= S_RUN;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_RUN: begin
               if (issue_s && last_s) begin
                  state_r <= S_DRAIN;
               end else begin
                  state_r <= S_RUN;
               end
            end
            S_DRAIN: begin
               if (pop_s && head_s.last) begin
                  finish_r <= 1'b1;
                  state_r  <= S_DONE;
               end else begin
                  state_r <= S_DRAIN;
               end
            end
            S_DONE: begin
               ready_r <= 1'b1;
               state_r <= S_IDLE;
            end
            default: state_r <= S_IDLE;
         endcase

         if (issue_s) begin
            if (col_r == col_last_s) begin
               col_r <= 9'd0;
               if (row_r == row_last_s) begin
                  row_r <= 9'd0;
                  ch_r  <= ch_r + 8'd1;
               end else begin
                  row_r <= row_r + 9'd1;
               end
            end else begin
               col_r <= col_r + 9'd1;
            end
         end

         rd_en_r <= issue_s && (tok_s == TOK_RD);
         if (issue_s && (tok_s == TOK_RD)) begin
            rd_addr_r  <= nxt_addr_r;
            nxt_addr_r <= nxt_addr_r + ADDR_WIDTH'(1);
         end

         a_valid_r <= issue_s;
         a_tok_r   <= tok_s;
         a_sol_r   <= sol_s;
         a_eoc_r   <= eoc_s;
         a_last_r  <= last_s;
         b_valid_r <= a_valid_r;
         b_tok_r   <= a_tok_r;
         b_sol_r   <= a_sol_r;
         b_eoc_r   <= a_eoc_r;
         b_last_r  <= a_last_r;
         // The high nibble waits here for the HI token that follows its byte.
         if (b_valid_r && (b_tok_r == TOK_RD)) begin
            held_hi_r <= fm_buf_data_i[7:4];
         end
      end
   end

endmodule

// File: tb/tb_fm_buf_reader.sv
// Bench for fm_buf_reader: table of jobs plus random jobs, each checked against
// a scan-order model of the padded/unpacked feature map.
module tb_fm_buf_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        ready, finish;
   logic [7:0]  w_num_i = 8'd0, h_num_i = 8'd0, c_num_i = 8'd0;
   logic        kernal_mode_i = 1'b0, bit_mode_i = 1'b0;
   logic [11:0] base_addr_i = 12'd0;
   logic        fm_buf_rd_en_o;
   logic [11:0] fm_buf_rd_addr_o;
   logic [7:0]  fm_buf_data_i = 8'd0;
   logic        fm_valid_o;
   logic        fm_ready_i = 1'b1;
   logic [7:0]  fm_data_o;
   logic        fm_sol_o, fm_eoc_o, fm_last_o;

   int tests = 0;
   int fails = 0;
   int finish_cnt = 0;
   logic [7:0]  mem [4096];
   logic [10:0] got_q[$], exp_q[$];
   logic [11:0] gota_q[$], expa_q[$];
   bit          hold_pend = 1'b0;
   logic [10:0] hold_beat;

   typedef struct {
      int w, h, c, k, b, base, pat, rmode, intrude;
      int exp_beats, exp_reads, exp_sum;
      string name;
   } vec_t;
   vec_t vec_q[$];

   fm_buf_reader #(.ADDR_WIDTH(12), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready), .finish(finish),
      .w_num_i(w_num_i), .h_num_i(h_num_i), .c_num_i(c_num_i),
      .kernal_mode_i(kernal_mode_i), .bit_mode_i(bit_mode_i), .base_addr_i(base_addr_i),
      .fm_buf_rd_en_o(fm_buf_rd_en_o), .fm_buf_rd_addr_o(fm_buf_rd_addr_o),
      .fm_buf_data_i(fm_buf_data_i), .fm_valid_o(fm_valid_o), .fm_ready_i(fm_ready_i),
      .fm_data_o(fm_data_o), .fm_sol_o(fm_sol_o), .fm_eoc_o(fm_eoc_o), .fm_last_o(fm_last_o)
   );

   always #5 clk = ~clk;

   // Buffer memory: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (fm_buf_rd_en_o) fm_buf_data_i <= mem[fm_buf_rd_addr_o];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: collects beats/reads/finish, checks hold-under-stall and FIFO bound.
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_pend && fm_valid_o) begin
            tests++;
            if ({fm_data_o, fm_sol_o, fm_eoc_o, fm_last_o} !== hold_beat) begin
               fails++;
               $display("FAIL hold: got %h expected %h", {fm_data_o, fm_sol_o, fm_eoc_o, fm_last_o}, hold_beat);
            end
         end
         hold_pend = fm_valid_o && !fm_ready_i;
         hold_beat = {fm_data_o, fm_sol_o, fm_eoc_o, fm_last_o};
         if (fm_valid_o && fm_ready_i) got_q.push_back({fm_data_o, fm_sol_o, fm_eoc_o, fm_last_o});
         if (fm_buf_rd_en_o) gota_q.push_back(fm_buf_rd_addr_o);
         if (finish) finish_cnt++;
         tests++;
         if (int'(dut.fifo_count_s) > 4) begin
            fails++;
            $display("FAIL fifo_bound: got %0d expected <= 4", dut.fifo_count_s);
         end
      end else begin
         hold_pend = 1'b0;
      end
   end

   task automatic add_vec(input int w, h, c, k, b, base, pat, rmode, intrude,
                          input int eb, er, es, input string name);
      vec_t v;
      v.w = w; v.h = h; v.c = c; v.k = k; v.b = b; v.base = base; v.pat = pat;
      v.rmode = rmode; v.intrude = intrude; v.exp_beats = eb; v.exp_reads = er;
      v.exp_sum = es; v.name = name;
      vec_q.push_back(v);
   endtask

   task automatic fill_mem(input int pat);
      logic [3:0] lo, hi;
      for (int i = 0; i < 4096; i++) begin
         lo = 4'(2 * i + 1);
         hi = 4'(2 * i + 2);
         if (pat == 0) mem[i] = 8'(i + 1);
         else if (pat == 1) mem[i] = {hi, lo};
         else mem[i] = 8'($urandom);
      end
   endtask

   // Reference: visit the padded grid in scan order, map interior pixels to bytes.
   task automatic build_model(input int w, h, c, k, b, base);
      int W = w + 1, H = h + 1;
      int wp = W + (k ? 2 : 0), hp = H + (k ? 2 : 0);
      int bpr = b ? (W + 1) / 2 : W;
      int x, y, a;
      logic [7:0] d;
      bit inner, eoc;
      exp_q.delete();
      expa_q.delete();
      for (int ch = 0; ch <= c; ch++)
         for (int r = 0; r < hp; r++)
            for (int col = 0; col < wp; col++) begin
               inner = !k || (r > 0 && r < hp - 1 && col > 0 && col < wp - 1);
               x = k ? col - 1 : col;
               y = k ? r - 1 : r;
               d = 8'd0;
               if (inner) begin
                  a = (base + (ch * H + y) * bpr + (b ? x / 2 : x)) % 4096;
                  d = mem[a];
                  if (b) d = (x % 2) ? (d >> 4) : (d & 8'h0f);
               end
               eoc = (col == wp - 1) && (r == hp - 1);
               exp_q.push_back({d, col == 0, eoc, eoc && ch == c});
            end
      for (int ch = 0; ch <= c; ch++)
         for (int r = 0; r < H; r++)
            for (int i = 0; i < bpr; i++)
               expa_q.push_back(12'((base + (ch * H + r) * bpr + i) % 4096));
   endtask

   task automatic start_job(input int w, h, c, k, b, base);
      int cyc = 0;
      while (!ready && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("ready_before_job", ready, 1);
      w_num_i = 8'(w); h_num_i = 8'(h); c_num_i = 8'(c);
      kernal_mode_i = k[0]; bit_mode_i = b[0]; base_addr_i = 12'(base);
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      w_num_i = 8'($urandom); h_num_i = 8'($urandom); c_num_i = 8'($urandom);
      kernal_mode_i = 1'($urandom); bit_mode_i = 1'($urandom); base_addr_i = 12'($urandom);
   endtask

   task automatic run_job(input vec_t v);
      int fc0, lat = -1, sum = 0, mm = -1;
      bit done = 1'b0, busy_ok = 1'b1;
      build_model(v.w, v.h, v.c, v.k, v.b, v.base);
      got_q.delete();
      gota_q.delete();
      fc0 = finish_cnt;
      start_job(v.w, v.h, v.c, v.k, v.b, v.base);
      for (int cyc = 1; cyc <= 5000 && !done; cyc++) begin
         if (lat < 0 && fm_valid_o) lat = cyc - 1;
         if (finish_cnt != fc0) begin
            done = 1'b1;
         end else begin
            if (ready) busy_ok = 1'b0;
            if (v.rmode == 0) fm_ready_i = 1'b1;
            else fm_ready_i = (cyc >= 8 && cyc < 18) ? 1'b0 : 1'($urandom);
            if (v.intrude != 0 && cyc == 5) begin
               valid = 1'b1;
               w_num_i = 8'd0; h_num_i = 8'd0; c_num_i = 8'd0;
               kernal_mode_i = ~v.k[0]; base_addr_i = 12'h800;
            end else begin
               valid = 1'b0;
            end
            @(posedge clk); #1;
         end
      end
      fm_ready_i = 1'b1;
      valid = 1'b0;
      chk({v.name, "_timeout"}, done, 1);
      chk({v.name, "_latency"}, lat, 3);
      chk({v.name, "_busy_not_ready"}, busy_ok, 1);
      chk({v.name, "_ready_after_finish"}, ready, 1);
      repeat (3) @(posedge clk);
      #1;
      chk({v.name, "_finish_once"}, finish_cnt - fc0, 1);
      chk({v.name, "_beats"}, got_q.size(), exp_q.size());
      if (v.exp_beats >= 0) chk({v.name, "_beats_hand"}, got_q.size(), v.exp_beats);
      if (v.exp_reads >= 0) chk({v.name, "_reads_hand"}, gota_q.size(), v.exp_reads);
      foreach (got_q[i]) sum += int'(got_q[i][10:3]);
      if (v.exp_sum >= 0) chk({v.name, "_sum_hand"}, sum, v.exp_sum);
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (mm < 0 && got_q[i] !== exp_q[i]) mm = i;
      tests++;
      if (mm >= 0) begin
         fails++;
         $display("FAIL %s_seq beat %0d: got %h expected %h", v.name, mm, got_q[mm], exp_q[mm]);
      end
      chk({v.name, "_nreads"}, gota_q.size(), expa_q.size());
      mm = -1;
      for (int i = 0; i < gota_q.size() && i < expa_q.size(); i++)
         if (mm < 0 && gota_q[i] !== expa_q[i]) mm = i;
      tests++;
      if (mm >= 0) begin
         fails++;
         $display("FAIL %s_addr read %0d: got %h expected %h", v.name, mm, gota_q[mm], expa_q[mm]);
      end
   endtask

   function automatic logic [27:0] rst_vec();
      return {ready, finish, fm_buf_rd_en_o, fm_valid_o, fm_sol_o, fm_eoc_o, fm_last_o,
              fm_buf_rd_addr_o, fm_data_o, 1'b0};
   endfunction

   initial begin
      logic [27:0] rst_exp;
      int cyc;
      rst_exp = {1'b1, 27'd0};
      //        w  h  c  k  b  base  pat rm in  beats reads sum
      add_vec(1, 1, 0, 0, 0, 0,    0, 0, 0,  4,  4,  10, "t1_1x1_8b");
      add_vec(1, 1, 0, 1, 0, 0,    0, 0, 0, 16,  4,  10, "t2_3x3_8b");
      add_vec(3, 0, 0, 0, 1, 0,    1, 0, 0,  4,  2,  10, "t3_4b_even");
      add_vec(2, 0, 0, 0, 1, 0,    1, 0, 0,  3,  2,   6, "t3_4b_odd");
      add_vec(3, 2, 1, 0, 0, 0,    0, 1, 0, 24, 24, 300, "t4_backpressure");
      add_vec(0, 0, 0, 0, 0, 7,    0, 0, 0,  1,  1,   8, "min_1x1x1");
      add_vec(0, 0, 0, 1, 0, 9,    0, 0, 0,  9,  1,  10, "min_3x3");
      add_vec(4, 1, 0, 1, 1, 4094, 2, 1, 0, 28,  6,  -1, "wrap_4b_3x3");
      add_vec(5, 3, 0, 0, 0, 0,    0, 0, 1, 24, 24, 300, "t6_valid_ignored");

      repeat (3) @(posedge clk);
      #1;
      chk("reset_state_in_reset", rst_vec(), rst_exp);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_state_after_release", rst_vec(), rst_exp);

      foreach (vec_q[i]) begin
         fill_mem(vec_q[i].pat);
         run_job(vec_q[i]);
      end

      // Reset in the middle of a running job, then a fresh job.
      fill_mem(0);
      got_q.delete();
      start_job(7, 3, 1, 1, 0, 100);
      cyc = 0;
      while (got_q.size() < 5 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("t5_reached_5_beats", got_q.size() >= 5, 1);
      #2 rst_n = 1'b0;
      #1 chk("t5_reset_mid_run", rst_vec(), rst_exp);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t5_idle_after_reset", rst_vec(), rst_exp);
      begin
         vec_t v;
         v.w = 2; v.h = 1; v.c = 1; v.k = 1; v.b = 0; v.base = 40; v.pat = 0;
         v.rmode = 0; v.intrude = 0; v.exp_beats = 40; v.exp_reads = 12; v.exp_sum = -1;
         v.name = "t5_job_after_reset";
         run_job(v);
      end

      // Random jobs.
      for (int r = 0; r < 6; r++) begin
         vec_t v;
         v.w = $urandom_range(0, 6); v.h = $urandom_range(0, 4); v.c = $urandom_range(0, 2);
         v.k = $urandom_range(0, 1); v.b = $urandom_range(0, 1); v.base = $urandom_range(0, 4095);
         v.pat = 2; v.rmode = $urandom_range(0, 1); v.intrude = $urandom_range(0, 1);
         v.exp_beats = -1; v.exp_reads = -1; v.exp_sum = -1;
         v.name = "rand";
         if (v.intrude != 0) v.w = v.w + 4;
         fill_mem(2);
         run_job(v);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
